// File: rtl/pipelined_rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder: default sizes,
// the stage-count helper and the parameter legality check.
package pipe_rca_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CHUNK_DEF = 4;

    // Number of pipeline stages; guarded so an illegal CHUNK of 0 cannot divide by zero
    function automatic int calc_stages(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // True when the operand width splits into whole chunks of a sensible size
    function automatic bit params_legal(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/pipelined_rca_if.sv
// Operand/result handshake bundle for pipelined_rca.
// Optional signed-overflow signal ovf exists only when PIPE_RCA_OVF_EN is defined.
interface pipelined_rca_if #(
    parameter int WIDTH = pipe_rca_pkg::WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_RCA_OVF_EN
    logic             ovf;
`endif

    // Producer of operands and consumer of results
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef PIPE_RCA_OVF_EN
        , input ovf
`endif
    );

    // The adder itself
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef PIPE_RCA_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/pipelined_rca_chunk.sv
// Combinational CHUNK-bit ripple adder used once per pipeline stage.
// cmsb is the carry into the top bit, needed for signed overflow.
module rca_chunk #(
    parameter int CHUNK = pipe_rca_pkg::CHUNK_DEF
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    // Ripple the carry bit by bit, capturing the carry entering the MSB on the way
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        cmsb  = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) cmsb = carry;
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder: WIDTH-bit operands summed CHUNK bits per stage,
// carry registered between stages, valid/ready on both sides with collapsing bubbles.
// Define PIPE_RCA_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_rca
    import pipe_rca_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    pipelined_rca_if.slave bus
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    generate
        if (!params_legal(WIDTH, CHUNK)) begin : g_bad_params
            $error("pipelined_rca: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
        end
    endgenerate

    // Stage registers; sum bits above the stage's top chunk stay zero by construction
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];

    // Per-stage inputs (from the bus for stage 0, else from the previous stage)
    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  s_src [STAGES];
    logic [WIDTH-1:0]  s_nxt [STAGES];
    logic [CHUNK-1:0]  chunk_sum [STAGES];
    logic [STAGES-1:0] c_src;
    logic [STAGES-1:0] c_nxt;
    logic [STAGES-1:0] m_nxt;
    logic [STAGES-1:0] v_src;
    logic [STAGES:0]   en;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign a_src[k] = bus.a;
                assign b_src[k] = bus.b;
                assign s_src[k] = '0;
                assign c_src[k] = bus.cin;
                assign v_src[k] = bus.in_valid;
            end else begin : g_next
                assign a_src[k] = a_q[k-1];
                assign b_src[k] = b_q[k-1];
                assign s_src[k] = s_q[k-1];
                assign c_src[k] = c_q[k-1];
                assign v_src[k] = v[k-1];
            end

            rca_chunk #(.CHUNK(CHUNK)) u_chunk (
                .a    (a_src[k][k*CHUNK +: CHUNK]),
                .b    (b_src[k][k*CHUNK +: CHUNK]),
                .cin  (c_src[k]),
                .sum  (chunk_sum[k]),
                .cout (c_nxt[k]),
                .cmsb (m_nxt[k])
            );

            assign s_nxt[k] = s_src[k] | (WIDTH'(chunk_sum[k]) << (k * CHUNK));
        end
    endgenerate

    // Enable chain from the output back: a stage advances if empty or if its successor advances
    always_comb begin
        en         = '0;
        en[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            en[k] = !v[k] || en[k+1];
        end
    end

    // Stage registers load together when enabled, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v   <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    v[k]   <= v_src[k];
                    c_q[k] <= c_nxt[k];
                    a_q[k] <= a_src[k];
                    b_q[k] <= b_src[k];
                    s_q[k] <= s_nxt[k];
                end
            end
        end
    end

`ifdef PIPE_RCA_OVF_EN
    logic ovf_q;

    // Signed overflow of the last chunk, registered alongside the last stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en[STAGES-1]) begin
            ovf_q <= m_nxt[STAGES-1] ^ c_nxt[STAGES-1];
        end
    end

    assign bus.ovf = ovf_q;
`endif

    // The last stage's operand copies and the lower-stage MSB carries have no consumer
    logic unused_bits;
    assign unused_bits = ^{m_nxt, a_q[STAGES-1], b_q[STAGES-1]};

    assign bus.in_ready  = en[0];
    assign bus.out_valid = v[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_rca.sv
// Self-checking bench for pipelined_rca: default 32/4 instance plus 8/8 and 16/1 instances.
// Honours PIPE_RCA_OVF_EN for the overflow checks on the small instances.
module tb_pipelined_rca;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipelined_rca_if #(.WIDTH(32)) bus32 ();
    pipelined_rca_if #(.WIDTH(8))  bus8 ();
    pipelined_rca_if #(.WIDTH(16)) bus16 ();

    pipelined_rca #(.WIDTH(32), .CHUNK(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    pipelined_rca #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    pipelined_rca #(.WIDTH(16), .CHUNK(1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    int checks = 0;
    int errors = 0;
    int out_count = 0;
    int acc_count = 0;
    int cycle_idx = 0;
    int first_out = -1;
    int last_out = -1;
    logic last_in_ready = 1'b0;

    logic [32:0] sb32 [$];
    logic [17:0] sb8 [$];
    logic [17:0] sb16 [$];

    // Reference for the 32-bit instance: {cout, sum}
    function automatic logic [32:0] model32(input logic [31:0] a, input logic [31:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + 33'(c);
    endfunction

    // Reference for a w-bit instance (w <= 16): {ovf, cout, 16-bit zero-extended sum}
    function automatic logic [17:0] model_small(input int w, input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] full;
        logic [15:0] s;
        logic        co;
        logic        ov;
        full = {1'b0, a} + {1'b0, b} + 17'(c);
        s    = 16'(full & ((17'd1 << w) - 17'd1));
        co   = full[w];
`ifdef PIPE_RCA_OVF_EN
        ov   = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
`else
        ov   = 1'b0;
`endif
        return {ov, co, s};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the 32-bit instance: drive at negedge, account transfers due at the next posedge
    task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                                 input logic ic, input logic ordy);
        logic [32:0] exp;
        @(negedge clk);
        bus32.in_valid  = iv;
        bus32.a         = ia;
        bus32.b         = ib;
        bus32.cin       = ic;
        bus32.out_ready = ordy;
        #1;
        last_in_ready = bus32.in_ready;
        if (bus32.in_valid && bus32.in_ready) begin
            sb32.push_back(model32(ia, ib, ic));
            acc_count++;
        end
        if (bus32.out_valid && bus32.out_ready) begin
            checkOutput("main.sb_nonempty", 64'(sb32.size() != 0), 64'd1);
            if (sb32.size() != 0) begin
                exp = sb32.pop_front();
                checkOutput("main.result", {31'd0, bus32.cout, bus32.sum}, 64'(exp));
            end
            out_count++;
            if (first_out < 0) first_out = cycle_idx;
            last_out = cycle_idx;
        end
        cycle_idx++;
    endtask

    // One clock of the 8/8 and 16/1 instances, same accounting scheme
    task automatic applyStimulusSmall(input logic iv8, input logic [7:0] a8, input logic [7:0] b8, input logic c8,
                                      input logic iv16, input logic [15:0] a16, input logic [15:0] b16, input logic c16,
                                      input logic ordy);
        logic [17:0] exp;
        logic        ov8;
        logic        ov16;
        @(negedge clk);
        bus8.in_valid   = iv8;
        bus8.a          = a8;
        bus8.b          = b8;
        bus8.cin        = c8;
        bus8.out_ready  = ordy;
        bus16.in_valid  = iv16;
        bus16.a         = a16;
        bus16.b         = b16;
        bus16.cin       = c16;
        bus16.out_ready = ordy;
        #1;
`ifdef PIPE_RCA_OVF_EN
        ov8  = bus8.ovf;
        ov16 = bus16.ovf;
`else
        ov8  = 1'b0;
        ov16 = 1'b0;
`endif
        if (bus8.in_valid && bus8.in_ready) sb8.push_back(model_small(8, {8'd0, a8}, {8'd0, b8}, c8));
        if (bus16.in_valid && bus16.in_ready) sb16.push_back(model_small(16, a16, b16, c16));
        if (bus8.out_valid && bus8.out_ready) begin
            checkOutput("dut8.sb_nonempty", 64'(sb8.size() != 0), 64'd1);
            if (sb8.size() != 0) begin
                exp = sb8.pop_front();
                checkOutput("dut8.result", 64'({ov8, bus8.cout, 8'd0, bus8.sum}), 64'(exp));
            end
        end
        if (bus16.out_valid && bus16.out_ready) begin
            checkOutput("dut16.sb_nonempty", 64'(sb16.size() != 0), 64'd1);
            if (sb16.size() != 0) begin
                exp = sb16.pop_front();
                checkOutput("dut16.result", 64'({ov16, bus16.cout, bus16.sum}), 64'(exp));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [31:0] front_sum;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.out_ready = 1'b0;
        bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.out_ready  = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b0;

        // Reset state
        #2;
        checkOutput("reset.out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("reset.sum", 64'(bus32.sum), 64'd0);
        checkOutput("reset.cout", 64'(bus32.cout), 64'd0);
        checkOutput("reset.small_valid", 64'({bus8.out_valid, bus16.out_valid}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset.in_ready", 64'(bus32.in_ready), 64'd1);

        // Single operation latency: accepted at edge N, visible after edge N+7
        @(negedge clk);
        bus32.in_valid = 1'b1; bus32.a = 32'hFFFF_FFFF; bus32.b = 32'h0000_0001; bus32.cin = 1'b0;
        bus32.out_ready = 1'b1;
        #1;
        checkOutput("latency.accept", 64'(bus32.in_ready), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            bus32.in_valid = 1'b0;
            #1;
            checkOutput("latency.out_valid", 64'(bus32.out_valid), 64'(i == 8));
            if (i == 8) begin
                checkOutput("latency.sum", 64'(bus32.sum), 64'd0);
                checkOutput("latency.cout", 64'(bus32.cout), 64'd1);
            end
        end

        // Back-to-back random stream, always ready
        out_count = 0; first_out = -1; last_out = -1;
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, $urandom(), $urandom(), 1'($urandom()), 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("b2b.count", 64'(out_count), 64'd100);
        checkOutput("b2b.one_per_clock", 64'(last_out - first_out), 64'd99);
        checkOutput("b2b.sb_empty", 64'(sb32.size()), 64'd0);

        // Back-pressure: fill with out_ready low
        acc_count = 0; out_count = 0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, $urandom(), $urandom(), 1'($urandom()), 1'b0);
        checkOutput("bp.accepts", 64'(acc_count), 64'd8);
        front_sum = sb32[0][31:0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("bp.in_ready_low", 64'(bus32.in_ready), 64'd0);
            checkOutput("bp.hold", {31'd0, bus32.out_valid, bus32.sum}, {31'd0, 1'b1, front_sum});
        end
        applyStimulus(1'b1, $urandom(), $urandom(), 1'($urandom()), 1'b1);
        checkOutput("bp.in_ready_same_cycle", 64'(last_in_ready), 64'd1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("bp.drained", 64'(out_count), 64'd9);
        checkOutput("bp.sb_empty", 64'(sb32.size()), 64'd0);

        // Bubbles with random back-pressure
        for (int i = 0; i < 200; i++) applyStimulus(1'(i % 2), $urandom(), $urandom(), 1'($urandom()), 1'($urandom()));
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("bubble.sb_empty", 64'(sb32.size()), 64'd0);

        // Reset in the middle of a stalled stream
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, $urandom(), $urandom(), 1'($urandom()), 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("midrst.sum", 64'(bus32.sum), 64'd0);
        checkOutput("midrst.cout", 64'(bus32.cout), 64'd0);
        sb32.delete();
        bus32.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst.in_ready", 64'(bus32.in_ready), 64'd1);
        out_count = 0;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("midrst.no_stale", 64'(out_count), 64'd0);

        // Small configurations: directed signed overflow case first
        applyStimulusSmall(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        @(posedge clk);
        #1;
`ifdef PIPE_RCA_OVF_EN
        checkOutput("dut8.ovf_7f01", 64'({bus8.out_valid, bus8.ovf, bus8.sum}), 64'({1'b1, 1'b1, 8'h80}));
`else
        checkOutput("dut8.sum_7f01", 64'({bus8.out_valid, bus8.cout, bus8.sum}), 64'({1'b1, 1'b0, 8'h80}));
`endif
        for (int i = 0; i < 80; i++) begin
            applyStimulusSmall(1'($urandom()), 8'($urandom()), 8'($urandom()), 1'($urandom()),
                               1'($urandom()), 16'($urandom()), 16'($urandom()), 1'($urandom()),
                               1'($urandom()));
        end
        for (int i = 0; i < 30; i++) applyStimulusSmall(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("dut8.sb_empty", 64'(sb8.size()), 64'd0);
        checkOutput("dut16.sb_empty", 64'(sb16.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
